// File: rtl/grad_clip_pkg.sv
// Shared types and constants for the 4D gradient-vector clipper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package grad_clip_pkg;

    // Q8.8 gradient component: 16 bits, 8 of them fractional.
    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 8;
    localparam int VEC_LEN = 4;
    localparam int SHIFT_W = 4;
    localparam int IDX_W   = 2;
    localparam int MAG_W   = DATA_W - 1;

    // Largest representable positive magnitude; -32768 saturates here.
    localparam logic [DATA_W-1:0] ABS_MAX = 16'h7FFF;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCALE   = 2'd1,
        EMIT    = 2'd2
    } state_e;

endpackage

// File: rtl/grad_vec_clipper_abs_sat16.sv
// Saturating absolute value of a signed 16-bit component (0x8000 -> 0x7FFF).
// Latency: combinational.
// Backpressure: none; pure function of its input.
module abs_sat16
    import grad_clip_pkg::*;
(
    input  logic [DATA_W-1:0] x_i,
    output logic [MAG_W-1:0]  mag_o
);

    logic [DATA_W-1:0] neg_dat;

    // Two's-complement negate for negative inputs; the most negative value
    // has no positive counterpart, so clamp it to the largest magnitude.
    always_comb begin
        neg_dat = '0;
        mag_o   = x_i[MAG_W-1:0];
        if (x_i[DATA_W-1]) begin
            if (x_i == {1'b1, {(DATA_W-1){1'b0}}}) begin
                mag_o = ABS_MAX[MAG_W-1:0];
            end else begin
                neg_dat = DATA_W'(~x_i + 1'b1);
                mag_o   = neg_dat[MAG_W-1:0];
            end
        end
    end

endmodule

// File: rtl/grad_vec_clipper.sv
// Collects a 4-component Q8.8 gradient, shifts all components right by the smallest k with max|g|>>k <= CLIP.
// Latency: 4th accept at t -> first output at t+k+2; no overlap of input and output phases.
// Backpressure: in_ready low outside collection; out_ready low holds grad_out/out_last/index.
module grad_vec_clipper
    import grad_clip_pkg::*;
#(
    parameter logic [DATA_W-1:0] CLIP    = 16'h0400,
    parameter int                VEC_LEN = 4
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    grad_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_W-1:0]    grad_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [SHIFT_W-1:0]   shift_amt,
    output logic                 clipped
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [SHIFT_W-1:0]  k_q;
    logic [MAG_W-1:0]    maxabs_q;
    logic [SHIFT_W-1:0]  shift_q;
    logic                clipped_q;
    logic                in_rdy_q;
    logic                out_vld_q;
    logic [DATA_W-1:0]   buf_q [VEC_LEN];

    logic [MAG_W-1:0]    in_mag;
    logic [MAG_W-1:0]    scaled_mag;
    logic                fits_clip;
    logic                in_acc;
    logic                out_hs;
    logic signed [DATA_W-1:0] cur_dat;
    logic signed [DATA_W-1:0] shifted_dat;

    abs_sat16 u_abs (
        .x_i   (grad_in),
        .mag_o (in_mag)
    );

    assign in_acc     = in_valid && in_rdy_q;
    assign out_hs     = out_vld_q && out_ready;

    // Magnitude is 15 bits; zero-extend so the compare against CLIP is unsigned.
    assign scaled_mag = maxabs_q >> k_q;
    assign fits_clip  = {1'b0, scaled_mag} <= CLIP;

    // Output datapath reads only registered state: buffer entry, index, shift.
    assign cur_dat     = buf_q[idx_q];
    assign shifted_dat = cur_dat >>> shift_q;

    assign in_ready  = in_rdy_q;
    assign out_valid = out_vld_q;
    assign grad_out  = out_vld_q ? shifted_dat : '0;
    assign out_last  = out_vld_q && (idx_q == LAST_IDX);
    assign shift_amt = shift_q;
    assign clipped   = clipped_q;

    // Component buffer; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (in_acc) begin
            buf_q[idx_q] <= grad_in;
        end
    end

    // Control FSM: collect four components, search the shift, then emit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            idx_q     <= '0;
            k_q       <= '0;
            maxabs_q  <= '0;
            shift_q   <= '0;
            clipped_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (in_acc) begin
                        idx_q <= idx_q + 1'b1;
                        if (in_mag > maxabs_q) begin
                            maxabs_q <= in_mag;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q  <= SCALE;
                            k_q      <= '0;
                            in_rdy_q <= 1'b0;
                        end
                    end
                end
                SCALE: begin
                    // At k=15 the shifted 15-bit magnitude is 0, so this always exits.
                    if (fits_clip) begin
                        shift_q   <= k_q;
                        clipped_q <= (k_q != '0);
                        idx_q     <= '0;
                        state_q   <= EMIT;
                        out_vld_q <= 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_hs) begin
                        if (idx_q == LAST_IDX) begin
                            state_q   <= COLLECT;
                            idx_q     <= '0;
                            maxabs_q  <= '0;
                            out_vld_q <= 1'b0;
                            in_rdy_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= COLLECT;
                    idx_q     <= '0;
                    maxabs_q  <= '0;
                    out_vld_q <= 1'b0;
                    in_rdy_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule
